aes_key_sched_serial: RTL and testbench

- Byte-serial AES-128 key-schedule controller; sits directly upstream of the combinational key-expansion S-box (8-bit in, 8-bit out, zero latency) and consumes what it produces.
- Feeds the S-box one RotWord byte per cycle and collects the SubWord result.
- Produces round keys 0..10 in sequence on a valid/ready stream to the round datapath.
- Uses one shared S-box instead of four.

---
 rtl/aes_key_sched_serial.sv | 188 ++++++++++++++++++
 tb/tb_aes_key_sched_serial.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_serial.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_serial
// Description : Byte-serial AES-128 key-schedule controller. Drives one
//               shared combinational S-box with the RotWord bytes of the
//               last word of the current round key, assembles SubWord and
//               streams round keys 0..NR out on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_serial #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_LAST_IDX  = 4'(NR);
    localparam logic [7:0] c_RCON_INIT = 8'h01;
    localparam logic [7:0] c_RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_SUB     = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [23:0]  temp_q, temp_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic         w_xfer;

    // Multiply by x in GF(2^8), used to advance the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) begin
            r = r ^ c_RCON_POLY;
        end
        return r;
    endfunction

    assign w_w0   = rk_data_q[127:96];
    assign w_w1   = rk_data_q[95:64];
    assign w_w2   = rk_data_q[63:32];
    assign w_w3   = rk_data_q[31:0];
    assign w_xfer = rk_valid_q && rk_ready;

    // RotWord byte selection: the counter walks w3 in rotated order; outside
    // SUB the counter is parked at 0 so the S-box input stays deterministic.
    always_comb begin
        sbox_in = w_w3[23:16];
        case (cnt_q)
            2'd0:    sbox_in = w_w3[23:16];
            2'd1:    sbox_in = w_w3[15:8];
            2'd2:    sbox_in = w_w3[7:0];
            default: sbox_in = w_w3[31:24];
        endcase
    end

    // Next round key: the last SubWord byte comes straight from the S-box,
    // so the final XOR chain completes in the same cycle as the 4th lookup.
    always_comb begin
        w_t  = {temp_q[23:16] ^ rcon_q, temp_q[15:8], temp_q[7:0], sbox_out};
        w_n0 = w_w0 ^ w_t;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;
    end

    // Next-state and register-update logic of the controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        temp_d     = temp_q;
        rcon_d     = rcon_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rk_data_d  = key_in;
                    rk_idx_d   = 4'd0;
                    rcon_d     = c_RCON_INIT;
                    rk_valid_d = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = S_PRESENT;
                end
            end

            S_PRESENT: begin
                if (w_xfer) begin
                    rk_valid_d = 1'b0;
                    cnt_d      = 2'd0;
                    if (rk_idx_q == c_LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SUB;
                    end
                end
            end

            S_SUB: begin
                case (cnt_q)
                    2'd0: begin
                        temp_d[23:16] = sbox_out;
                        cnt_d         = 2'd1;
                    end
                    2'd1: begin
                        temp_d[15:8] = sbox_out;
                        cnt_d        = 2'd2;
                    end
                    2'd2: begin
                        temp_d[7:0] = sbox_out;
                        cnt_d       = 2'd3;
                    end
                    default: begin
                        rk_data_d  = {w_n0, w_n1, w_n2, w_n3};
                        rk_idx_d   = rk_idx_q + 4'd1;
                        rcon_d     = xtime(rcon_q);
                        rk_valid_d = 1'b1;
                        cnt_d      = 2'd0;
                        state_d    = S_PRESENT;
                    end
                endcase
            end

            default: begin
                state_d    = S_IDLE;
                cnt_d      = 2'd0;
                rk_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            temp_q     <= 24'd0;
            rcon_q     <= c_RCON_INIT;
            rk_data_q  <= 128'd0;
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            temp_q     <= temp_d;
            rcon_q     <= rcon_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign rk_valid = rk_valid_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_serial
// Description : Self-checking bench for aes_key_sched_serial. Supplies the
//               S-box, models the FIPS-197 key expansion word by word and
//               compares every valid round key against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_serial;

    localparam int NR = 10;
    localparam logic [127:0] c_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ZERO_KEY  = 128'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic         done;

    int n_checks  = 0;
    int n_pass    = 0;
    int runs_done = 0;
    int exp_idx   = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic fin_prev = 1'b0;
    logic [127:0] exp_keys [11];

    aes_key_sched_serial #(.NR(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // AES forward S-box, one 16-byte row per high nibble.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    always_comb sbox_out = sb(sbox_in);

    // Reference key expansion over 44 words, FIPS-197 style.
    task automatic load_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Consumer handshake driver.
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       rk_ready = 1'b1;
            1:       rk_ready = 1'($urandom_range(0, 1));
            default: rk_ready = 1'b0;
        endcase
    end

    // Stream monitor: every valid round key, transfer order and done pulse.
    always @(negedge clk) begin
        if (rst) begin
            exp_idx  = 0;
            fin_prev = 1'b0;
        end else begin
            if (done || fin_prev) begin
                check("done_pulse", 128'(done), 128'(fin_prev));
                if (done) begin
                    check("xfer_count", 128'(exp_idx), 128'd11);
                    exp_idx = 0;
                    runs_done++;
                end
            end
            if (rk_valid) begin
                check("rk_idx", 128'(rk_idx), 128'(exp_idx));
                check("busy_when_valid", 128'(busy), 128'd1);
                if (exp_idx <= NR) check("rk_data", rk_data, exp_keys[exp_idx]);
            end
            fin_prev = rk_valid && rk_ready && (rk_idx == 4'(NR));
            if (rk_valid && rk_ready) exp_idx++;
        end
    end

    // Issue one start pulse; caller is at posedge+1 with the DUT idle.
    task automatic start_run(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        load_model(key);
        @(posedge clk); #1;
        start = 1'b0;
        check("r0_valid", 128'(rk_valid), 128'd1);
        check("r0_data", rk_data, key);
        check("r0_idx", 128'(rk_idx), 128'd0);
    endtask

    // Wait for the monitor to see done, optionally pulsing start while busy.
    task automatic wait_run(input int budget, input bit pulse);
        int base;
        int k;
        base = runs_done;
        k = 0;
        while (runs_done == base && k < budget) begin
            @(posedge clk); #1;
            if (pulse && busy && $urandom_range(0, 7) == 0) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            k++;
        end
        start = 1'b0;
        check("run_completes", 128'(runs_done != base), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] exp_sb [4];
        rst = 1'b1; start = 1'b0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rk_data", rk_data, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_sbox_in", 128'(sbox_in), 128'd0);
        rst = 1'b0;

        // Pin the model against published vectors.
        load_model(c_FIPS_KEY);
        check("model_fips_rk1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_fips_rk10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        load_model(c_ZERO_KEY);
        check("model_zero_rk1", exp_keys[1], 128'h62636363626363636263636362636363);
        check("model_zero_rk10", exp_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // FIPS key, always ready: S-box byte order and SUB latency.
        ready_mode = 0;
        @(posedge clk); #1;
        start_run(c_FIPS_KEY);
        exp_sb[0] = 8'hcf; exp_sb[1] = 8'h4f; exp_sb[2] = 8'h3c; exp_sb[3] = 8'h09;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sub_sbox_in", 128'(sbox_in), 128'(exp_sb[i]));
            check("sub_valid_low", 128'(rk_valid), 128'd0);
        end
        @(negedge clk);
        check("sub_latency_valid", 128'(rk_valid), 128'd1);
        check("sub_latency_idx", 128'(rk_idx), 128'd1);
        wait_run(200, 1'b0);

        // All-zero key, includes the 80 -> 1b round-constant wrap.
        @(posedge clk); #1;
        start_run(c_ZERO_KEY);
        wait_run(200, 1'b0);

        // Backpressure: stall at round 3 for 7 cycles, then random ready.
        @(posedge clk); #1;
        start_run(c_FIPS_KEY);
        k = 0;
        do begin @(negedge clk); k++; end while (!(rk_idx == 4'd2 && !rk_valid) && k < 100);
        ready_mode = 2;
        k = 0;
        do begin @(negedge clk); k++; end while (!(rk_valid && rk_idx == 4'd3) && k < 100);
        check("stall_reached", 128'(k < 100), 128'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_valid", 128'(rk_valid), 128'd1);
            check("stall_data", rk_data, exp_keys[3]);
        end
        ready_mode = 1;
        wait_run(2000, 1'b0);

        // Reset in the middle of SUB after round 5 is transferred.
        ready_mode = 0;
        @(posedge clk); #1;
        start_run(c_FIPS_KEY);
        k = 0;
        do begin @(negedge clk); k++; end while (!(rk_valid && rk_ready && rk_idx == 4'd5) && k < 200);
        check("reach_round5", 128'(k < 200), 128'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_rk_data", rk_data, 128'd0);
        check("abort_rk_idx", 128'(rk_idx), 128'd0);
        check("abort_valid", 128'(rk_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_sbox_in", 128'(sbox_in), 128'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_partial", 128'(rk_valid), 128'd0);
        start_run(c_ZERO_KEY);
        wait_run(200, 1'b0);

        // Start pulses while busy, then start exactly on the done edge.
        @(posedge clk); #1;
        start_run(c_FIPS_KEY);
        k = 0;
        forever begin
            @(posedge clk); #1;
            k++;
            if ((rk_valid && rk_idx == 4'(NR)) || k > 200) break;
            if ($urandom_range(0, 2) == 0) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
        end
        check("reach_round10", 128'(k <= 200), 128'd1);
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        check("done_edge_done", 128'(done), 128'd1);
        check("done_edge_ignored", 128'(rk_valid), 128'd0);
        check("done_edge_idle", 128'(busy), 128'd0);
        key_in = c_ZERO_KEY;
        load_model(c_ZERO_KEY);
        @(posedge clk); #1;
        start = 1'b0;
        check("after_done_accept", 128'(rk_valid), 128'd1);
        check("after_done_data", rk_data, c_ZERO_KEY);
        wait_run(200, 1'b0);

        // Random keys, random backpressure, stray start pulses while busy.
        ready_mode = 1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #1;
            start_run({$urandom, $urandom, $urandom, $urandom});
            wait_run(3000, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
